// File: rtl/apb_pkg.sv
// Shared definitions for the two-requester round-robin APB master:
// bus widths, slave-select bit, default timeout and FSM state encodings.
package apb_pkg;

   localparam int SLV_SEL_BIT = 8;
   localparam int APB_ADDR_W  = SLV_SEL_BIT + 1;
   localparam int APB_DATA_W  = 8;
   localparam int DEF_TIMEOUT = 16;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_SETUP  = 2'd1;
   localparam state_t ST_ACCESS = 2'd2;

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin arbiter. The requester that was not granted last wins
// a tie; the pointer only moves when the owner accepts a grant.
module apb_rr_arb2 (
   input  logic       PCLK,
   input  logic       PRESET,
   input  logic [1:0] valid,
   input  logic       upd,
   output logic [1:0] grant
);

   logic last;

   // NOTE: every path assigns grant, so no latch is inferred.
   always_comb begin
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // Reset to 1 so requester 0 wins the first contention.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET)
         last <= 1'b1;
      else if (upd && (grant != 2'b00))
         last <= grant[1];
   end

endmodule

// File: rtl/apb_rr_master.sv
// Two-requester APB master: round-robin grant, IDLE/SETUP/ACCESS sequencing,
// PADDR MSB slave decode and ACCESS-phase timeout with error completion.
module apb_rr_master
   import apb_pkg::*;
#(
   parameter int ADDR_W  = APB_ADDR_W,
   parameter int DATA_W  = APB_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              req0_valid,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              req0_done,
   output logic [DATA_W-1:0] req0_rdata,
   output logic              req0_err,
   input  logic              req1_valid,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              req1_done,
   output logic [DATA_W-1:0] req1_rdata,
   output logic              req1_err,
   output logic              PSEL1,
   output logic              PSEL2,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic              PREADY1,
   input  logic              PREADY2,
   input  logic [DATA_W-1:0] PRDATA1,
   input  logic [DATA_W-1:0] PRDATA2
);

   state_t                 state;
   logic                   owner;
   logic [7:0]             cnt;
   logic [1:0]             grant;
   logic                   arb_en;
   logic                   sel_ready;
   logic [DATA_W-1:0]      sel_rdata;
   logic [1:0]             done_q;
   logic [1:0]             err_q;
   logic [1:0][DATA_W-1:0] rdata_q;
   logic                   g_write;
   logic [ADDR_W-1:0]      g_addr;
   logic [DATA_W-1:0]      g_wdata;

   assign arb_en = (state == ST_IDLE) && !PRESET;

   apb_rr_arb2 u_arb (
      .PCLK   (PCLK),
      .PRESET (PRESET),
      .valid  ({req1_valid, req0_valid}),
      .upd    (arb_en),
      .grant  (grant)
   );

   assign req0_ready = grant[0] && arb_en;
   assign req1_ready = grant[1] && arb_en;

   assign g_write = grant[1] ? req1_write : req0_write;
   assign g_addr  = grant[1] ? req1_addr  : req0_addr;
   assign g_wdata = grant[1] ? req1_wdata : req0_wdata;

   // Only the addressed slave's handshake is observed.
   assign sel_ready = PADDR[ADDR_W-1] ? PREADY2 : PREADY1;
   assign sel_rdata = PADDR[ADDR_W-1] ? PRDATA2 : PRDATA1;

   assign req0_done  = done_q[0];
   assign req1_done  = done_q[1];
   assign req0_err   = err_q[0];
   assign req1_err   = err_q[1];
   assign req0_rdata = rdata_q[0];
   assign req1_rdata = rdata_q[1];

   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state   <= ST_IDLE;
         owner   <= 1'b0;
         cnt     <= '0;
         PSEL1   <= 1'b0;
         PSEL2   <= 1'b0;
         PENABLE <= 1'b0;
         PWRITE  <= 1'b0;
         PADDR   <= '0;
         PWDATA  <= '0;
         done_q  <= '0;
         err_q   <= '0;
         rdata_q <= '0;
      end else begin
         // Completion outputs are single-cycle pulses.
         done_q  <= '0;
         err_q   <= '0;
         rdata_q <= '0;
         case (state)
            ST_IDLE: begin
               if (grant != 2'b00) begin
                  owner  <= grant[1];
                  PWRITE <= g_write;
                  PADDR  <= g_addr;
                  PWDATA <= g_wdata;
                  PSEL1  <= !g_addr[ADDR_W-1];
                  PSEL2  <= g_addr[ADDR_W-1];
                  state  <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               PENABLE <= 1'b1;
               cnt     <= '0;
               state   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (sel_ready || (cnt == 8'(TIMEOUT - 1))) begin
                  done_q[owner]  <= 1'b1;
                  err_q[owner]   <= !sel_ready;
                  rdata_q[owner] <= (sel_ready && !PWRITE) ? sel_rdata : '0;
                  PSEL1          <= 1'b0;
                  PSEL2          <= 1'b0;
                  PENABLE        <= 1'b0;
                  state          <= ST_IDLE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master with two memory-backed APB slave models
// that raise PREADY one cycle after seeing PENABLE.
module tb_apb_rr_master;

   logic       PCLK = 1'b0;
   logic       PRESET;
   logic       req0_valid, req0_write, req1_valid, req1_write;
   logic [8:0] req0_addr, req1_addr;
   logic [7:0] req0_wdata, req1_wdata;
   logic       req0_ready, req0_done, req0_err;
   logic       req1_ready, req1_done, req1_err;
   logic [7:0] req0_rdata, req1_rdata;
   logic       PSEL1, PSEL2, PENABLE, PWRITE;
   logic [8:0] PADDR;
   logic [7:0] PWDATA;
   logic       PREADY1, PREADY2;
   logic [7:0] PRDATA1, PRDATA2;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] mem1 [256];
   logic [7:0] mem2 [256];
   logic       p1_q = 1'b0, p2_q = 1'b0, loaded = 1'b0;
   logic       stray1 = 1'b0, slv2_dead = 1'b0;

   always #5 PCLK = ~PCLK;

   apb_rr_master dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
      .req0_rdata(req0_rdata), .req0_err(req0_err),
      .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
      .req1_rdata(req1_rdata), .req1_err(req1_err),
      .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA),
      .PREADY1(PREADY1), .PREADY2(PREADY2), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2)
   );

   assign PREADY1 = p1_q | stray1;
   assign PREADY2 = p2_q & !slv2_dead;
   assign PRDATA1 = mem1[PADDR[7:0]];
   assign PRDATA2 = mem2[PADDR[7:0]];

   always @(posedge PCLK) begin
      if (!loaded) begin
         for (int i = 0; i < 256; i++) begin
            mem1[i] <= 8'h00;
            mem2[i] <= 8'h00;
         end
         mem2[8'h0F] <= 8'h3C;
         mem2[8'h00] <= 8'h5A;
         loaded <= 1'b1;
      end else begin
         p1_q <= PSEL1 && PENABLE && !p1_q;
         p2_q <= PSEL2 && PENABLE && !p2_q;
         if (PSEL1 && PENABLE && p1_q && PWRITE) mem1[PADDR[7:0]] <= PWDATA;
         if (PSEL2 && PENABLE && p2_q && PWRITE && !slv2_dead) mem2[PADDR[7:0]] <= PWDATA;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int n, input bit v, input bit w, input logic [8:0] a,
                        input logic [7:0] d);
      if (n == 0) begin
         req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
      end else begin
         req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
      end
   endtask

   task automatic step();
      @(posedge PCLK);
      #1;
   endtask

   // Issue one command and wait for its completion pulse; lat counts cycles
   // from the accept cycle to the done cycle.
   task automatic xfer(input int n, input bit w, input logic [8:0] a, input logic [7:0] d,
                       output logic [7:0] rd, output bit er, output int lat);
      int k = 0;
      drive(n, 1'b1, w, a, d);
      #1;
      while (!(n ? req1_ready : req0_ready) && k < 50) begin
         step();
         #1;
         k++;
      end
      if (k == 50) check("ready_wait", 0, 1);
      step();
      drive(n, 1'b0, w, a, d);
      lat = 1;
      while (!(n ? req1_done : req0_done) && lat < 60) begin
         step();
         lat++;
      end
      if (lat == 60) check("done_wait", 0, 1);
      rd = n ? req1_rdata : req0_rdata;
      er = n ? req1_err : req0_err;
   endtask

   initial begin
      logic [7:0] rd;
      bit         er;
      int         lat, k, acc;
      int         order [4];
      bit         overlap, extra, prev0, prev1, dup;

      PRESET = 1'b1;
      drive(0, 1'b1, 1'b1, 9'h020, 8'h11);
      drive(1, 1'b1, 1'b1, 9'h130, 8'h22);
      repeat (3) @(posedge PCLK);
      #1;
      check("rst_psel1", PSEL1, 0);
      check("rst_psel2", PSEL2, 0);
      check("rst_penable", PENABLE, 0);
      check("rst_pwrite", PWRITE, 0);
      check("rst_paddr", PADDR, 0);
      check("rst_pwdata", PWDATA, 0);
      check("rst_done", {req0_done, req1_done, req0_err, req1_err}, 0);
      check("rst_ready_forced", {req0_ready, req1_ready}, 0);

      // Arbitration: both requesters held valid from reset.
      PRESET = 1'b0;
      k = 0; overlap = 0; dup = 0; prev0 = 0; prev1 = 0;
      for (int c = 0; c < 40 && k < 4; c++) begin
         #1;
         if (PSEL1 && PSEL2) overlap = 1;
         if ((req0_ready && prev0) || (req1_ready && prev1) || (req0_ready && req1_ready))
            dup = 1;
         prev0 = req0_ready;
         prev1 = req1_ready;
         if (req0_ready) begin order[k] = 0; k++; end
         else if (req1_ready) begin order[k] = 1; k++; end
         if (k < 4) step();
      end
      check("arb_count", k, 4);
      check("arb_g0", order[0], 0);
      check("arb_g1", order[1], 1);
      check("arb_g2", order[2], 0);
      check("arb_g3", order[3], 1);
      step();
      drive(0, 1'b0, 1'b0, 9'h000, 8'h00);
      drive(1, 1'b0, 1'b0, 9'h000, 8'h00);
      for (int c = 0; c < 6; c++) begin
         if (PSEL1 && PSEL2) overlap = 1;
         step();
      end
      check("arb_one_psel", overlap, 0);
      check("arb_ready_pulse", dup, 0);

      // Write with cycle-exact latency checks.
      drive(0, 1'b1, 1'b1, 9'h005, 8'hA5);
      #1;
      check("w_ready0_T", req0_ready, 1);
      step();
      drive(0, 1'b0, 1'b1, 9'h005, 8'hA5);
      check("w_setup_bus", {PSEL1, PSEL2, PENABLE, PWRITE}, 4'b1001);
      check("w_setup_paddr", PADDR, 9'h005);
      check("w_setup_pwdata", PWDATA, 8'hA5);
      step();
      check("w_access", {PSEL1, PENABLE}, 2'b11);
      step();
      check("w_done_T3", req0_done, 0);
      step();
      check("w_done_T4", {req0_done, req0_err}, 2'b10);
      step();
      check("w_done_pulse", req0_done, 0);

      xfer(0, 1'b0, 9'h005, 8'h00, rd, er, lat);
      check("r_rdata0", rd, 8'hA5);
      check("r_err0", er, 0);
      check("r_lat", lat, 4);
      step();

      // Slave-2 decode with a stray PREADY1 during ACCESS.
      drive(1, 1'b1, 1'b0, 9'h10F, 8'h00);
      #1;
      check("d_ready1", req1_ready, 1);
      step();
      drive(1, 1'b0, 1'b0, 9'h10F, 8'h00);
      check("d_setup_sel", {PSEL1, PSEL2}, 2'b01);
      check("d_paddr", PADDR, 9'h10F);
      step();
      check("d_access", {PSEL1, PSEL2, PENABLE}, 3'b011);
      stray1 = 1'b1;
      step();
      stray1 = 1'b0;
      check("d_stray_ignored", {req1_done, PSEL1, PSEL2}, 3'b001);
      step();
      check("d_done", {req1_done, req1_err}, 2'b10);
      check("d_rdata1", req1_rdata, 8'h3C);
      step();

      // Timeout on a dead slave 2.
      slv2_dead = 1'b1;
      drive(0, 1'b1, 1'b0, 9'h100, 8'h00);
      #1;
      check("t_ready0", req0_ready, 1);
      step();
      drive(0, 1'b0, 1'b0, 9'h100, 8'h00);
      acc = 0;
      for (int c = 0; c < 60 && !req0_done; c++) begin
         if (PENABLE) acc++;
         step();
      end
      check("t_access_cycles", acc, 16);
      check("t_done_err", {req0_done, req0_err}, 2'b11);
      check("t_rdata0", req0_rdata, 8'h00);
      check("t_bus_idle", {PSEL1, PSEL2, PENABLE}, 0);
      slv2_dead = 1'b0;
      step();
      xfer(0, 1'b0, 9'h100, 8'h00, rd, er, lat);
      check("t_next_rdata", rd, 8'h5A);
      check("t_next_err_lat", {er, 8'(lat)}, {1'b0, 8'd4});
      step();

      // Reset asserted during ACCESS.
      drive(0, 1'b1, 1'b1, 9'h050, 8'h77);
      #1;
      check("x_ready0", req0_ready, 1);
      step();
      drive(0, 1'b0, 1'b1, 9'h050, 8'h77);
      step();
      check("x_in_access", {PSEL1, PENABLE}, 2'b11);
      PRESET = 1'b1;
      #1;
      check("x_async_drop", {PSEL1, PSEL2, PENABLE}, 0);
      extra = 0;
      step();
      if (req0_done || req1_done) extra = 1;
      PRESET = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (req0_done || req1_done) extra = 1;
         step();
      end
      check("x_no_done", extra, 0);
      xfer(1, 1'b1, 9'h1AA, 8'h99, rd, er, lat);
      check("x_req1_lat", lat, 4);
      check("x_req1_err", er, 0);
      step();
      drive(0, 1'b1, 1'b0, 9'h050, 8'h00);
      drive(1, 1'b1, 1'b0, 9'h1AA, 8'h00);
      #1;
      check("x_contend", {req0_ready, req1_ready}, 2'b10);
      step();
      drive(0, 1'b0, 1'b0, 9'h050, 8'h00);
      drive(1, 1'b0, 1'b0, 9'h1AA, 8'h00);
      lat = 1;
      while (!req0_done && lat < 20) begin
         step();
         lat++;
      end
      check("x_lost_write", {req0_done, req0_rdata}, {1'b1, 8'h00});
      step();
      xfer(0, 1'b0, 9'h1AA, 8'h00, rd, er, lat);
      check("x_req1_wrote", rd, 8'h99);
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Two-requester APB master that shares one APB bus across two slaves, each with 8-bit data and 256 locations.
- Arbitrates between requesters 0 and 1 round-robin, then sequences the APB IDLE/SETUP/ACCESS phases.
- Decodes PADDR[8] to choose the slave select, waits for that slave's PREADY, and returns read data or a timeout error to the granted requester.
- Sits between system initiators and the APB slave fabric.

Parameters:
- ADDR_W, 9: APB address width; bit ADDR_W-1 selects the slave.
- DATA_W, 8: APB data width.
- TIMEOUT, 16: maximum ACCESS-phase cycles without PREADY before the transfer aborts with an error; must be 2..255.

Ports:
- PCLK  in  1  APB clock; all logic on the rising edge.
- PRESET  in  1  Asynchronous reset, active-high.
- reqN_valid  in  1  Requester N (N=0,1) has a command; held until reqN_ready.
- reqN_write  in  1  1 = write, 0 = read.
- reqN_addr  in  ADDR_W  Target address.
- reqN_wdata  in  DATA_W  Write data.
- reqN_ready  out  1  Command accepted this cycle; combinational.
- reqN_done  out  1  One-cycle completion pulse; registered.
- reqN_rdata  out  DATA_W  Read data; valid while reqN_done is high.
- reqN_err  out  1  Timeout flag; valid while reqN_done is high.
- PSEL1 / PSEL2  out  1  Slave selects; PADDR[8]=0 selects slave 1, PADDR[8]=1 selects slave 2.
- PENABLE  out  1  ACCESS-phase strobe.
- PWRITE  out  1  Transfer direction.
- PADDR  out  ADDR_W  Transfer address.
- PWDATA  out  DATA_W  Transfer write data.
- PREADY1 / PREADY2  in  1  Slave ready signals.
- PRDATA1 / PRDATA2  in  DATA_W  Slave read data.

Behaviour:
- Reset (async, PRESET=1):
  - State = IDLE.
  - PSEL1, PSEL2, PENABLE, PWRITE = 0; PADDR, PWDATA = 0.
  - All reqN_done, reqN_err = 0; all reqN_rdata = 0.
  - Timeout counter = 0; round-robin pointer last = 1, so requester 0 wins first.
  - reqN_ready is forced 0 while PRESET is high.
- FSM states: IDLE, SETUP, ACCESS. All bus outputs are registered.
- IDLE:
  - With no valid request, PSELx = PENABLE = 0; PADDR, PWDATA and PWRITE hold their last values.
  - If exactly one reqN_valid is high, grant N. If both are high, grant the requester that is not last.
  - On grant: reqN_ready = 1 for that cycle only; latch write, addr and wdata; set last = N; next state SETUP.
- SETUP, exactly 1 cycle:
  - Decoded PSELx = 1, PENABLE = 0, bus fields driven from the latch.
  - Next state ACCESS; timeout counter cleared.
- ACCESS:
  - PENABLE = 1, PSELx held. Sample the PREADY of the selected slave only; the other slave's PREADY is ignored.
  - PREADY high: capture the selected PRDATA into reqN_rdata (reads only; writes leave rdata = 0), reqN_done = 1 and reqN_err = 0 in the next cycle. Drop PSELx and PENABLE; next state IDLE.
  - PREADY low: increment the counter. When the counter reaches TIMEOUT-1 with PREADY still low, next cycle reqN_done = 1, reqN_err = 1, reqN_rdata = 0; drop PSELx and PENABLE; go to IDLE.
- reqN_done and reqN_err are single-cycle pulses, low in every other cycle.
- Latency: with the command accepted in cycle T, SETUP is T+1 and ACCESS starts T+2. A slave that raises PREADY one cycle after seeing PENABLE gives PREADY at T+3 and done at T+4. A new command may be accepted in the done cycle.
- Only one transfer is outstanding at a time. A requester that was not granted keeps valid high and is served next, so there is no starvation.
- A requester may drop valid before ready; nothing is latched in that case.
- Reset during SETUP or ACCESS: bus outputs drop immediately, no done pulse is issued, and the transfer is lost.

Decomposition:
- Shared package apb_pkg holds:
  - The state enum (IDLE, SETUP, ACCESS).
  - ADDR_W and DATA_W defaults.
  - SLV_SEL_BIT = 8.
  - The default TIMEOUT constant.
- One sub-module, apb_rr_arb2:
  - Two-way round-robin grant with the last-grant pointer.
  - Inputs: valid pair and an update enable. Output: one-hot grant.

Test Plan:
- Write: req0 write addr 0x005, data 0xA5 at T, slave 1 model responds as above -> ready0 at T, PSEL1 at T+1, PENABLE at T+2, done0 at T+4 with err0 = 0. A following read of 0x005 returns rdata0 = 0xA5.
- Slave decode: req1 read addr 0x10F -> PSEL2 = 1, PSEL1 = 0 throughout, PADDR = 0x10F. rdata1 equals slave 2 mem[0x0F]. A stray PREADY1 pulse during this ACCESS is ignored.
- Arbitration: req0 and req1 both held valid from reset for 4 transfers -> grant order 0, 1, 0, 1; each ready is a one-cycle pulse; at most one PSEL is high at any time.
- Timeout: PREADY2 tied 0, TIMEOUT = 16, req0 read 0x100 -> exactly 16 ACCESS cycles, then done0 = 1, err0 = 1, rdata0 = 0x00; the bus returns to IDLE and the next request completes normally.
- Reset mid-transfer: assert PRESET during ACCESS -> PSEL and PENABLE go to 0 without waiting for a clock edge, and no done pulse occurs. After release, a req1 write completes with standard latency, and requester 0 wins the next contention.
